// File: rtl/ordered_update_bank_pkg.sv
// Shared types and width helpers for the ordered update bank.
// ORDERED_UPDATE_BANK_TS_EN adds a timestamp field to evt_t.
package ordered_update_pkg;

  function automatic int addr_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // The occupancy count must represent DEPTH itself, so it needs one extra bit.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int DEF_NUM_REG = 4;
  localparam int DEF_WIDTH   = 8;
  localparam int DEF_TS_W    = 16;
  localparam int DEF_ADDR_W  = addr_w(DEF_NUM_REG);

  typedef struct packed {
`ifdef ORDERED_UPDATE_BANK_TS_EN
    logic [DEF_TS_W-1:0]   ts;
`endif
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_WIDTH-1:0]  data;
  } evt_t;

endpackage

// File: rtl/ordered_update_bank_if.sv
// Write/read/event bus of the ordered update bank; master = update sources and monitor.
// ORDERED_UPDATE_BANK_TS_EN adds the evt_ts signal and its TS_W parameter.
interface ordered_update_bank_if import ordered_update_pkg::*; #(
  parameter int NUM_WR  = 2,
  parameter int NUM_REG = 4,
  parameter int WIDTH   = 8
`ifdef ORDERED_UPDATE_BANK_TS_EN
  , parameter int TS_W  = 16
`endif
);
  localparam int AW = addr_w(NUM_REG);

  logic [NUM_WR-1:0]       wr_valid;
  logic [NUM_WR*AW-1:0]    wr_addr;
  logic [NUM_WR*WIDTH-1:0] wr_data;
  logic [AW-1:0]           rd_addr;
  logic [WIDTH-1:0]        rd_data;
  logic                    evt_valid;
  logic                    evt_ready;
  logic [AW-1:0]           evt_addr;
  logic [WIDTH-1:0]        evt_data;
  logic                    evt_coalesced;
`ifdef ORDERED_UPDATE_BANK_TS_EN
  logic [TS_W-1:0]         evt_ts;
`endif

  modport master (
    output wr_valid, wr_addr, wr_data, rd_addr, evt_ready,
    input  rd_data, evt_valid, evt_addr, evt_data, evt_coalesced
`ifdef ORDERED_UPDATE_BANK_TS_EN
    , input evt_ts
`endif
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_addr, evt_ready,
    output rd_data, evt_valid, evt_addr, evt_data, evt_coalesced
`ifdef ORDERED_UPDATE_BANK_TS_EN
    , output evt_ts
`endif
  );

endinterface

// File: rtl/ordered_update_bank_evt_fifo.sv
// First-word-fall-through event FIFO; the head entry is visible while not empty.
// A push is accepted when full if a pop happens on the same edge.
module ordered_update_evt_fifo import ordered_update_pkg::*; #(
  parameter int ENTRY_W = 10,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push_i,
  input  logic [ENTRY_W-1:0] din_i,
  input  logic               pop_i,
  output logic [ENTRY_W-1:0] dout_o,
  output logic               full_o,
  output logic               empty_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]      count_q, count_d;
  logic               do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/ordered_update_bank.sv
// Multi-writer register bank with deterministic same-cycle resolution and a change-event FIFO.
// ORDERED_UPDATE_BANK_TS_EN adds a free-running cycle counter and per-event timestamps.
module ordered_update_bank import ordered_update_pkg::*; #(
  parameter int               NUM_WR    = 2,
  parameter int               NUM_REG   = 4,
  parameter int               WIDTH     = 8,
  parameter int               LAST_WINS = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               EVT_DEPTH = 4,
  parameter int               TS_W      = 16
) (
  input logic               clk,
  input logic               rst,
  ordered_update_bank_if.slave bus
);
  localparam int AW = addr_w(NUM_REG);

  typedef struct packed {
`ifdef ORDERED_UPDATE_BANK_TS_EN
    logic [TS_W-1:0]  ts;
`endif
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  if (NUM_WR < 1 || NUM_WR > 8) begin : g_bad_num_wr
    $error("NUM_WR must be 1..8");
  end
  if (NUM_REG < 2 || (NUM_REG & (NUM_REG - 1)) != 0) begin : g_bad_num_reg
    $error("NUM_REG must be a power of two >= 2");
  end
  if (EVT_DEPTH < 2 || (EVT_DEPTH & (EVT_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("EVT_DEPTH must be a power of two >= 2");
  end
  if (TS_W < 1) begin : g_bad_ts_w
    $error("TS_W must be >= 1");
  end

  logic [WIDTH-1:0]   reg_val [NUM_REG];
  logic [NUM_REG-1:0] change;
  logic [NUM_REG-1:0] pend_q, pend_d, push_clr;
  logic               coal_q, coal_d;
  logic               scan_any, push, pop;
  logic [AW-1:0]      scan_idx;
  logic               fifo_full, fifo_empty;
  logic [ENTRY_W-1:0] fifo_dout;
  entry_t             push_entry, head_entry;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REG; gi++) begin : g_reg
      logic             hit;
      logic [WIDTH-1:0] win;
      logic [WIDTH-1:0] val_q;

      always_comb begin
        hit = 1'b0;
        win = val_q;
        for (int w = 0; w < NUM_WR; w++) begin
          if (bus.wr_valid[w] && bus.wr_addr[w*AW +: AW] == AW'(gi)) begin
            if (LAST_WINS != 0 || !hit) win = bus.wr_data[w*WIDTH +: WIDTH];
            hit = 1'b1;
          end
        end
      end

      assign change[gi]  = hit && (win != val_q);
      assign reg_val[gi] = val_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst)             val_q <= RESET_VAL;
        else if (change[gi]) val_q <= win;
      end
    end
  endgenerate

  always_comb begin
    scan_idx = '0;
    for (int r = NUM_REG - 1; r >= 0; r--) begin
      if (pend_q[r]) scan_idx = AW'(r);
    end
  end

  assign scan_any = |pend_q;
  assign pop      = !fifo_empty && bus.evt_ready;
  assign push     = scan_any && (!fifo_full || pop);
  assign push_clr = push ? (NUM_REG'(1) << scan_idx) : '0;

  // A change landing on the register being pushed re-arms it without counting as
  // coalesced: the pushed event holds the old value and a new event will follow.
  always_comb begin
    pend_d = change | (pend_q & ~push_clr);
    coal_d = coal_q | (|(change & pend_q & ~push_clr));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
      coal_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      coal_q <= coal_d;
    end
  end

`ifdef ORDERED_UPDATE_BANK_TS_EN
  logic [TS_W-1:0] ts_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ts_q <= '0;
    else     ts_q <= ts_q + 1'b1;
  end
`endif

  always_comb begin
    push_entry      = '0;
    push_entry.addr = scan_idx;
    push_entry.data = reg_val[scan_idx];
`ifdef ORDERED_UPDATE_BANK_TS_EN
    push_entry.ts   = ts_q;
`endif
  end

  ordered_update_evt_fifo #(
    .ENTRY_W (ENTRY_W),
    .DEPTH   (EVT_DEPTH)
  ) u_evt_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (push_entry),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign head_entry        = fifo_dout;
  assign bus.rd_data       = reg_val[bus.rd_addr];
  assign bus.evt_valid     = !fifo_empty;
  assign bus.evt_addr      = head_entry.addr;
  assign bus.evt_data      = head_entry.data;
  assign bus.evt_coalesced = coal_q;
`ifdef ORDERED_UPDATE_BANK_TS_EN
  assign bus.evt_ts        = head_entry.ts;
`endif

endmodule

// File: tb/tb_ordered_update_bank.sv
// Directed + random bench for ordered_update_bank: one LAST_WINS=1 and one LAST_WINS=0
// instance driven identically, each checked every cycle against a queue-based model.
module tb_ordered_update_bank;
  import ordered_update_pkg::*;

  localparam int NUM_WR    = 2;
  localparam int NUM_REG   = 4;
  localparam int WIDTH     = 8;
  localparam int EVT_DEPTH = 4;
  localparam int TS_W      = 16;
  localparam int AW        = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ordered_update_bank_if #(.NUM_WR(NUM_WR), .NUM_REG(NUM_REG), .WIDTH(WIDTH)
`ifdef ORDERED_UPDATE_BANK_TS_EN
    , .TS_W(TS_W)
`endif
  ) bus0 (), bus1 ();

  ordered_update_bank #(
    .NUM_WR(NUM_WR), .NUM_REG(NUM_REG), .WIDTH(WIDTH), .LAST_WINS(1),
    .RESET_VAL(8'h00), .EVT_DEPTH(EVT_DEPTH), .TS_W(TS_W)
  ) u_dut_last (.clk(clk), .rst(rst), .bus(bus0));

  ordered_update_bank #(
    .NUM_WR(NUM_WR), .NUM_REG(NUM_REG), .WIDTH(WIDTH), .LAST_WINS(0),
    .RESET_VAL(8'h00), .EVT_DEPTH(EVT_DEPTH), .TS_W(TS_W)
  ) u_dut_first (.clk(clk), .rst(rst), .bus(bus1));

  logic [NUM_WR-1:0]       wv;
  logic [NUM_WR*AW-1:0]    wa;
  logic [NUM_WR*WIDTH-1:0] wd;
  logic [AW-1:0]           ra;
  logic                    er;

  assign bus0.wr_valid = wv;  assign bus1.wr_valid = wv;
  assign bus0.wr_addr  = wa;  assign bus1.wr_addr  = wa;
  assign bus0.wr_data  = wd;  assign bus1.wr_data  = wd;
  assign bus0.rd_addr  = ra;  assign bus1.rd_addr  = ra;
  assign bus0.evt_ready = er; assign bus1.evt_ready = er;

  logic             o_valid [2];
  logic [AW-1:0]    o_addr  [2];
  logic [WIDTH-1:0] o_data  [2];
  logic [WIDTH-1:0] o_rd    [2];
  logic             o_coal  [2];
  assign o_valid[0] = bus0.evt_valid;     assign o_valid[1] = bus1.evt_valid;
  assign o_addr[0]  = bus0.evt_addr;      assign o_addr[1]  = bus1.evt_addr;
  assign o_data[0]  = bus0.evt_data;      assign o_data[1]  = bus1.evt_data;
  assign o_rd[0]    = bus0.rd_data;       assign o_rd[1]    = bus1.rd_data;
  assign o_coal[0]  = bus0.evt_coalesced; assign o_coal[1]  = bus1.evt_coalesced;
`ifdef ORDERED_UPDATE_BANK_TS_EN
  logic [TS_W-1:0]  o_ts [2];
  assign o_ts[0] = bus0.evt_ts;
  assign o_ts[1] = bus1.evt_ts;
`endif

  // Reference model: instance 0 = last writer wins, instance 1 = first writer wins.
  logic [WIDTH-1:0] m_regs [2][NUM_REG];
  bit               m_pend [2][NUM_REG];
  bit               m_coal [2];
  evt_t             m_q    [2][$];
  int unsigned      m_ts;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < NUM_REG; r++) begin
        m_regs[k][r] = 8'h00;
        m_pend[k][r] = 1'b0;
      end
      m_coal[k] = 1'b0;
      m_q[k].delete();
    end
    m_ts = 0;
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      logic [WIDTH-1:0] nv  [NUM_REG];
      bit               chg [NUM_REG];
      int               pushed;
      bit               popped;
      int               occ;
      evt_t             e;
      for (int r = 0; r < NUM_REG; r++) begin
        bit found = 1'b0;
        nv[r] = m_regs[k][r];
        for (int w = 0; w < NUM_WR; w++) begin
          if (wv[w] && int'(wa[w*AW +: AW]) == r) begin
            if (k == 0 || !found) nv[r] = wd[w*WIDTH +: WIDTH];
            found = 1'b1;
          end
        end
        chg[r] = found && (nv[r] != m_regs[k][r]);
      end
      popped = (m_q[k].size() != 0) && er;
      occ    = m_q[k].size() - (popped ? 1 : 0);
      pushed = -1;
      if (occ < EVT_DEPTH) begin
        for (int r = NUM_REG - 1; r >= 0; r--) if (m_pend[k][r]) pushed = r;
      end
      e = '0;
      if (pushed >= 0) begin
        e.addr = AW'(pushed);
        e.data = m_regs[k][pushed];
`ifdef ORDERED_UPDATE_BANK_TS_EN
        e.ts   = TS_W'(m_ts);
`endif
      end
      for (int r = 0; r < NUM_REG; r++) begin
        if (chg[r] && m_pend[k][r] && r != pushed) m_coal[k] = 1'b1;
        m_pend[k][r] = chg[r] || (m_pend[k][r] && r != pushed);
        if (chg[r]) m_regs[k][r] = nv[r];
      end
      if (popped) begin
        $display("k%0d pop addr=%0d data=0x%02h", k, m_q[k][0].addr, m_q[k][0].data);
        void'(m_q[k].pop_front());
      end
      if (pushed >= 0) m_q[k].push_back(e);
    end
    m_ts++;
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("k%0d evt_valid", k), 32'(o_valid[k]), 32'(m_q[k].size() != 0));
      if (m_q[k].size() != 0) begin
        check_eq($sformatf("k%0d evt_addr", k), 32'(o_addr[k]), 32'(m_q[k][0].addr));
        check_eq($sformatf("k%0d evt_data", k), 32'(o_data[k]), 32'(m_q[k][0].data));
`ifdef ORDERED_UPDATE_BANK_TS_EN
        check_eq($sformatf("k%0d evt_ts", k), 32'(o_ts[k]), 32'(m_q[k][0].ts));
`endif
      end
      check_eq($sformatf("k%0d coalesced", k), 32'(o_coal[k]), 32'(m_coal[k]));
      check_eq($sformatf("k%0d rd_data[%0d]", k, ra), 32'(o_rd[k]), 32'(m_regs[k][ra]));
    end
  endtask

  // Called at a negedge with inputs already set; ends at the next negedge.
  task automatic step();
    #1;
    compare_all();
    @(posedge clk);
    if (!rst) model_edge();
    @(negedge clk);
  endtask

  task automatic drive(input logic [1:0] v, input logic [3:0] a, input logic [15:0] d, input logic r);
    wv = v; wa = a; wd = d; er = r;
  endtask

  task automatic idle(input int n);
    wv = '0;
    for (int i = 0; i < n; i++) step();
  endtask

  logic [AW-1:0]    exp_a [5];
  logic [WIDTH-1:0] exp_d [5];

  initial begin
    wv = '0; wa = '0; wd = '0; ra = '0; er = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_eq("in_reset evt_valid", 32'(o_valid[0]), 32'd0);
    check_eq("in_reset coalesced", 32'(o_coal[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Reset state on every address.
    for (int a = 0; a < NUM_REG; a++) begin
      ra = AW'(a);
      idle(1);
      #1;
      check_eq("reset rd_data", 32'(o_rd[0]), 32'd0);
    end

    // Two writers on addr1 in one cycle.
    ra = 2'd1;
    drive(2'b11, {2'd1, 2'd1}, {8'h01, 8'h00}, 1'b1);
    step();
    idle(1);
    #1;
    check_eq("lastwins rd1", 32'(o_rd[0]), 32'h01);
    check_eq("firstwins rd1", 32'(o_rd[1]), 32'h00);
    check_eq("lastwins evt_valid", 32'(o_valid[0]), 32'd1);
    check_eq("lastwins evt_addr", 32'(o_addr[0]), 32'd1);
    check_eq("lastwins evt_data", 32'(o_data[0]), 32'h01);
    check_eq("firstwins no evt", 32'(o_valid[1]), 32'd0);
    idle(2);
    #1;
    check_eq("lastwins one evt", 32'(o_valid[0]), 32'd0);

    // Same value twice on addr2 with consumer stalled.
    drive(2'b01, {2'd0, 2'd2}, {8'h00, 8'h55}, 1'b0);
    step();
    step();
    idle(2);
    #1;
    check_eq("dup evt_addr", 32'(o_addr[0]), 32'd2);
    check_eq("dup evt_data", 32'(o_data[0]), 32'h55);
    check_eq("dup coalesced", 32'(o_coal[0]), 32'd0);
    er = 1'b1;
    idle(2);
    #1;
    check_eq("dup single evt", 32'(o_valid[0]), 32'd0);

    // Two registers in one cycle drain in index order.
    drive(2'b11, {2'd3, 2'd0}, {8'h33, 8'h11}, 1'b1);
    step();
    idle(1);
    #1;
    check_eq("order first addr", 32'(o_addr[0]), 32'd0);
    check_eq("order first data", 32'(o_data[0]), 32'h11);
    idle(1);
    #1;
    check_eq("order second addr", 32'(o_addr[0]), 32'd3);
    check_eq("order second data", 32'(o_data[0]), 32'h33);
    idle(2);

    // Fill the FIFO, re-dirty addr0, then drain with nothing lost.
    drive(2'b11, {2'd1, 2'd0}, {8'hB1, 8'hA1}, 1'b0);
    step();
    drive(2'b11, {2'd3, 2'd2}, {8'hD3, 8'hC3}, 1'b0);
    step();
    idle(3);
    drive(2'b01, {2'd0, 2'd0}, {8'h00, 8'hA2}, 1'b0);
    step();
    idle(2);
    #1;
    check_eq("full head addr", 32'(o_addr[0]), 32'd0);
    check_eq("full head data", 32'(o_data[0]), 32'hA1);
    check_eq("full coalesced", 32'(o_coal[0]), 32'd0);
    exp_a = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd0};
    exp_d = '{8'hB1, 8'hC3, 8'hD3, 8'hA2, 8'h00};
    er = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle(1);
      #1;
      check_eq($sformatf("drain%0d addr", i), 32'(o_addr[0]), 32'(exp_a[i]));
      check_eq($sformatf("drain%0d data", i), 32'(o_data[0]), 32'(exp_d[i]));
    end
    idle(1);
    #1;
    check_eq("drain empty", 32'(o_valid[0]), 32'd0);

    // Reset with three events queued.
    drive(2'b11, {2'd2, 2'd1}, {8'h62, 8'h61}, 1'b0);
    step();
    drive(2'b01, {2'd0, 2'd3}, {8'h00, 8'h63}, 1'b0);
    step();
    idle(3);
    ra = 2'd2;
    #1;
    check_eq("pre_rst evt_valid", 32'(o_valid[0]), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("mid_rst evt_valid", 32'(o_valid[0]), 32'd0);
    check_eq("mid_rst rd_data", 32'(o_rd[0]), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Post-reset write at edge 4 is pushed at edge 5.
    idle(4);
    drive(2'b01, {2'd0, 2'd1}, {8'h00, 8'h7E}, 1'b0);
    step();
    idle(1);
    #1;
    check_eq("post_rst evt_addr", 32'(o_addr[0]), 32'd1);
`ifdef ORDERED_UPDATE_BANK_TS_EN
    check_eq("post_rst evt_ts", 32'(o_ts[0]), 32'd5);
`endif

    // Random traffic: small data range provokes collisions and same-value writes.
    for (int i = 0; i < 1500; i++) begin
      wv = NUM_WR'($urandom);
      wa = (NUM_WR*AW)'($urandom);
      for (int w = 0; w < NUM_WR; w++) wd[w*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 3));
      er = ($urandom_range(0, 3) != 0);
      ra = AW'($urandom);
      step();
    end
    idle(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ordered_update_bank.md
Name: ordered_update_bank

Overview:
- Parametrised register bank with `NUM_WR` same-cycle writers.
- Same-cycle writes to one register are resolved deterministically by a fixed writer-order mode.
- Each committed value change is recorded as a change event, in the manner of an `@(reg)` trigger.
- Events are buffered in a FIFO for a downstream monitor or trace unit; sits between concurrent update sources and trace/debug logic.

Parameters:
- `NUM_WR`, 2, number of write ports (1..8).
- `NUM_REG`, 4, number of registers (power of 2, ≥2).
- `WIDTH`, 8, register data width.
- `LAST_WINS`, 1, 1: highest-index valid writer wins; 0: lowest-index wins.
- `RESET_VAL`, 0, reset value of every register.
- `EVT_DEPTH`, 4, event FIFO depth (power of 2, ≥2).
- `TS_W`, 16, timestamp width (used only with the optional feature).

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous active-high reset.
- `wr_valid`  in  `NUM_WR`  per-writer write strobe.
- `wr_addr`  in  `NUM_WR*clog2(NUM_REG)`  per-writer register index, packed, writer 0 in the LSBs.
- `wr_data`  in  `NUM_WR*WIDTH`  per-writer data, packed.
- `rd_addr`  in  `clog2(NUM_REG)`  read index.
- `rd_data`  out  `WIDTH`  committed value of `rd_addr`, combinational.
- `evt_valid`  out  1  event FIFO non-empty.
- `evt_ready`  in  1  consumer pop.
- `evt_addr`  out  `clog2(NUM_REG)`  head event register index.
- `evt_data`  out  `WIDTH`  head event value.
- `evt_coalesced`  out  1  sticky: a change hit an already-pending register.
- `evt_ts`  out  `TS_W`  head event timestamp (present only with the optional feature).

Behaviour:
- Reset is asynchronous. While it is asserted:
  - all registers = `RESET_VAL`;
  - pending bitmap = 0;
  - FIFO empty, so `evt_valid` = 0;
  - `evt_coalesced` = 0;
  - timestamp = 0.
- Writes sampled at edge t commit at edge t; the new value is visible on `rd_data` in the following cycle.
- Resolution per register: consider the set of valid writers targeting it.
  - `LAST_WINS=1` selects the highest index; `LAST_WINS=0` selects the lowest.
  - Losing writes are discarded with no event and no flag.
- Change detection: a register's pending bit is set only if the committed value differs from its pre-edge value. A write of the same value creates no event.
- If a change occurs on a register whose pending bit is already 1, set `evt_coalesced`. It clears only on reset.
- Scanner, one push per cycle, when FIFO not full and any pending bit is set:
  - select the lowest-index pending register;
  - push {index, current committed value};
  - clear that pending bit.
- Same-edge push and new change on the same register: the new change has priority, so the pending bit stays set.
  - The pushed event carries the pre-edge value.
  - A second event with the new value follows.
- The FIFO never drops events; the scanner stalls while the FIFO is full.
- Pop when `evt_valid && evt_ready`. Simultaneous push and pop while full is allowed (the occupancy check uses the post-pop count).
- Latency: a write at edge t gives earliest `evt_valid` at t+1 (FIFO empty, no lower-index pending).
- FIFO pointers wrap at `EVT_DEPTH`. The occupancy counter is `clog2(EVT_DEPTH)+1` bits.
- Reset mid-operation discards all pending and queued events.

Optional Feature:
- Macro: `ORDERED_UPDATE_BANK_TS_EN`.
- Defined:
  - a free-running `TS_W`-bit cycle counter runs from reset, incrementing every cycle and wrapping to 0;
  - each pushed event stores the counter value at its push edge;
  - port `evt_ts` exists.
- Undefined: no counter, no `evt_ts` port, FIFO entry = addr+data only.

Decomposition:
- Package `ordered_update_pkg`:
  - `evt_t` struct {addr, data, optional ts};
  - localparam helpers for address width and count width.
- One sub-module, `ordered_update_evt_fifo`: synchronous FIFO parametrised on entry width and depth, with async active-high reset.

Test Plan:
- Reset, then read all addresses → `rd_data`=`RESET_VAL`, `evt_valid`=0, `evt_coalesced`=0.
- `LAST_WINS=1`; writer0 writes addr1=0x00 and writer1 writes addr1=0x01 in the same cycle → `rd_data`[1]=0x01; exactly one event {1,0x01}. Same stimulus with `LAST_WINS=0` → value 0x00, no event (equal to reset value).
- Write addr2=0x55 twice on consecutive cycles with `evt_ready`=0 → one event {2,0x55}; `evt_coalesced` stays 0.
- Write addr0=0x11 and addr3=0x33 in one cycle, consumer ready → events {0,0x11} then {3,0x33} on consecutive cycles.
- `evt_ready`=0; change addr0..3 plus a second change to addr0 (`EVT_DEPTH`=4) → FIFO full with 4 events, addr0 re-pending, `evt_coalesced`=0. Release `evt_ready` → fifth event {0,new value}, nothing lost.
- Assert `rst` mid-stream with 3 queued events → `evt_valid` drops immediately, registers return to `RESET_VAL`. With TS enabled: first post-reset event at cycle 5 reports `evt_ts`=5.
